// File: rtl/apb4_pkg.sv
// Shared definitions for the APB4 memory completer: FSM encoding, LFSR constants,
// wait-mode encodings and the address-decode error check.
package apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int WAIT_MODE_FIXED = 0;
    localparam int WAIT_MODE_LFSR  = 1;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: feedback taps bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic decode_err(input logic [63:0] addr, input logic [63:0] base,
                                        input logic [63:0] depth, input int lsb);
        logic [63:0] off;
        if (addr < base)
            return 1'b1;
        off = addr - base;
        if ((off >> lsb) >= depth)
            return 1'b1;
        if ((addr & ((64'd1 << lsb) - 64'd1)) != 64'd0)
            return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/apb_wait_lfsr.sv
// Pseudo-random wait-state source: 16-bit LFSR stepped once per accepted setup,
// low bits saturated to MAX_WAIT.
module apb_wait_lfsr
    import apb4_pkg::*;
#(
    parameter int MAX_WAIT = 3,
    parameter int N_W      = 3
) (
    input  logic           PCLK,
    input  logic           PRESET,
    input  logic           adv,
    output logic [N_W-1:0] n
);

    localparam int RAW_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [15:0]      lfsr;
    logic [RAW_W-1:0] raw;

    always_ff @(posedge PCLK) begin
        if (PRESET)
            lfsr <= LFSR_SEED;
        else if (adv)
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    assign raw = lfsr[RAW_W-1:0];
    assign n   = (32'(raw) > 32'(MAX_WAIT)) ? N_W'(MAX_WAIT) : N_W'(raw);

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 completer with an internal byte-lane-writable memory, fixed or LFSR wait states,
// and PSLVERR on out-of-range or misaligned addresses. All outputs are registered.
module apb4_slave_mem
    import apb4_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 256,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          MAX_WAIT    = 3
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WMAX  = (WAIT_CYCLES > MAX_WAIT) ? WAIT_CYCLES : MAX_WAIT;
    localparam int CNT_W = $clog2(WMAX + 2);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      idx_q, idx_now;
    logic                  err_q, err_now;
    logic [CNT_W-1:0]      cnt, cnt_nxt, wait_n, lfsr_n;
    logic                  setup;
    logic                  pready_nxt, pslverr_nxt, mem_we;
    logic [DATA_WIDTH-1:0] prdata_nxt;

    assign setup   = (state == ST_IDLE) && PSEL && !PENABLE;
    assign idx_now = IDX_W'((PADDR - ADDR_WIDTH'(BASE_ADDR)) >> LSB);
    assign err_now = decode_err(64'(PADDR), BASE_ADDR, 64'(DEPTH), LSB);
    assign wait_n  = (WAIT_MODE == WAIT_MODE_LFSR) ? lfsr_n : CNT_W'(WAIT_CYCLES);

    apb_wait_lfsr #(
        .MAX_WAIT (MAX_WAIT),
        .N_W      (CNT_W)
    ) u_wait_lfsr (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .adv    (setup),
        .n      (lfsr_n)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (PSEL && !PENABLE) state_nxt = (wait_n == '0) ? ST_ACCESS : ST_WAIT;
            ST_WAIT:   if (!PSEL) state_nxt = ST_IDLE;
                       else if (cnt == CNT_W'(1)) state_nxt = ST_ACCESS;
            ST_ACCESS: if (!PSEL || PENABLE) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; read data is captured as PREADY rises
    always_comb begin
        cnt_nxt     = cnt;
        pready_nxt  = PREADY;
        pslverr_nxt = PSLVERR;
        prdata_nxt  = PRDATA;
        mem_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    if (wait_n == '0) begin
                        cnt_nxt     = '0;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = err_now;
                        prdata_nxt  = err_now ? '0 : mem[idx_now];
                    end else begin
                        cnt_nxt     = wait_n;
                        pready_nxt  = 1'b0;
                        pslverr_nxt = 1'b0;
                        prdata_nxt  = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    cnt_nxt     = '0;
                    pready_nxt  = 1'b0;
                    pslverr_nxt = 1'b0;
                    prdata_nxt  = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        pready_nxt  = 1'b1;
                        pslverr_nxt = err_q;
                        prdata_nxt  = err_q ? '0 : mem[idx_q];
                    end
                end
            end
            ST_ACCESS: begin
                if (!PSEL || PENABLE) begin
                    pready_nxt  = 1'b0;
                    pslverr_nxt = 1'b0;
                    prdata_nxt  = '0;
                    mem_we      = PSEL && PENABLE && PWRITE && !err_q;
                end
            end
            default: begin
                cnt_nxt     = '0;
                pready_nxt  = 1'b0;
                pslverr_nxt = 1'b0;
                prdata_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            cnt     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int w = 0; w < DEPTH; w++)
                mem[w] <= '0;
        end else begin
            PREADY  <= pready_nxt;
            PSLVERR <= pslverr_nxt;
            PRDATA  <= prdata_nxt;
            cnt     <= cnt_nxt;
            if (setup) begin
                idx_q <= idx_now;
                err_q <= err_now;
            end
            if (mem_we) begin
                for (int b = 0; b < BYTES; b++)
                    if (PSTRB[b])
                        mem[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Bench for apb4_slave_mem: three instances (zero wait, fixed 3 waits, LFSR waits)
// on a shared APB bus with per-instance PSEL.
module tb_apb4_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata [3];
    logic [2:0]  pready, pslverr;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    apb4_slave_mem #(.WAIT_MODE(0), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb4_slave_mem #(.WAIT_MODE(0), .WAIT_CYCLES(3)) u_dut1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb4_slave_mem #(.WAIT_MODE(1), .MAX_WAIT(3)) u_dut2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] rmem [256];
    logic [15:0] lfsr_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // One complete APB transfer on instance d; returns read data, error and wait count
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rd, output logic er, output int waits);
        psel = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = wd;
        pstrb = strb;
        chk("setup_pready_low", 64'(pready[d]), 64'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!pready[d] && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!pready[d]) begin
            chk("pready_timeout", 64'd0, 64'd1);
            rd = '0;
            er = 1'b0;
        end else begin
            rd = prdata[d];
            er = pslverr[d];
        end
        @(posedge clk); #1;
        psel = 3'b000;
        penable = 1'b0;
        chk("post_complete_pready_low", 64'(pready[d]), 64'd0);
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a >= 32'h400) || (a % 4 != 0);
    endfunction

    function automatic int next_wait();
        int n;
        int fb;
        n = int'(lfsr_m) % 4;
        if (n > 3) n = 3;
        fb = (int'(lfsr_m) ^ (int'(lfsr_m) >> 2) ^ (int'(lfsr_m) >> 3) ^ (int'(lfsr_m) >> 5)) & 1;
        lfsr_m = 16'((int'(lfsr_m) >> 1) | (fb << 15));
        return n;
    endfunction

    initial begin
        logic [31:0] rd, addr, wd, mask, exp_rd;
        logic        er, wr, eb;
        logic [3:0]  strb;
        int          waits, ew;

        rst = 1'b1;
        psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
        for (int i = 0; i < 256; i++) rmem[i] = '0;
        lfsr_m = 16'hACE1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            chk("reset_pready", 64'(pready[d]), 64'd0);
            chk("reset_pslverr", 64'(pslverr[d]), 64'd0);
            chk("reset_prdata", 64'(prdata[d]), 64'd0);
        end

        vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h020, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h020, 32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h024, 32'h12345678, 4'h0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h024, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h402, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h400, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h012, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b0, 32'h012, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[14] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};

        for (int v = 0; v < 16; v++) begin
            xfer(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, rd, er, waits);
            chk($sformatf("vec%0d_err", v), 64'(er), 64'(vecs[v].exp_err));
            chk($sformatf("vec%0d_waits", v), 64'(waits), 64'd0);
            if (!vecs[v].wr)
                chk($sformatf("vec%0d_rdata", v), 64'(rd), 64'(vecs[v].exp_rd));
        end

        // Fixed three wait states, then an abort in the middle of the wait
        xfer(1, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, rd, er, waits);
        chk("w3_write_waits", 64'(waits), 64'd3);
        xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, waits);
        chk("w3_read_waits", 64'(waits), 64'd3);
        chk("w3_read_data", 64'(rd), 64'h0BADF00D);
        chk("w3_read_err", 64'(er), 64'd0);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30;
        pwdata = 32'h99999999; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        chk("abort_pready", 64'(pready[1]), 64'd0);
        xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, waits);
        chk("abort_mem_unchanged", 64'(rd), 64'h0BADF00D);
        chk("abort_next_waits", 64'(waits), 64'd3);

        // Random back-to-back traffic on the LFSR-wait instance against the model
        for (int t = 0; t < 32; t++) begin
            wr = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) addr = 32'h400 + addr;
            else if ($urandom_range(0, 7) == 0) addr = addr | 32'h1;
            wd = $urandom;
            strb = 4'($urandom_range(0, 15));
            eb = addr_bad(addr);
            ew = next_wait();
            exp_rd = eb ? 32'h0 : rmem[addr[9:2]];
            xfer(2, wr, addr, wd, strb, rd, er, waits);
            chk($sformatf("rnd%0d_waits", t), 64'(waits), 64'(ew));
            chk($sformatf("rnd%0d_wait_range", t), 64'(waits <= 3), 64'd1);
            chk($sformatf("rnd%0d_err", t), 64'(er), 64'(eb));
            if (!wr)
                chk($sformatf("rnd%0d_rdata", t), 64'(rd), 64'(exp_rd));
            else if (!eb) begin
                mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
                rmem[addr[9:2]] = (rmem[addr[9:2]] & ~mask) | (wd & mask);
            end
        end

        // Reset while a write sits in its wait states
        xfer(1, 1'b1, 32'h10, 32'h76543210, 4'hF, rd, er, waits);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; psel = 3'b000; penable = 1'b0;
        lfsr_m = 16'hACE1;
        chk("midwait_reset_pready", 64'(pready[1]), 64'd0);
        chk("midwait_reset_prdata", 64'(prdata[1]), 64'd0);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, waits);
        chk("after_reset_mem_zero", 64'(rd), 64'd0);
        chk("after_reset_waits", 64'(waits), 64'd3);
        ew = next_wait();
        xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, waits);
        chk("after_reset_lfsr_wait", 64'(waits), 64'(ew));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
